// File: rtl/btb_pkg.sv
// Shared types for the branch-resolution slice: the per-fetch prediction record
// and the sequential-PC helper used by both predicted and actual next-PC paths.
package btb_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            taken;
        logic [XLEN-1:0] target;
    } pred_entry_t;

    // Fall-through address; wraps modulo 2^XLEN.
    function automatic logic [XLEN-1:0] seq_pc(input logic [XLEN-1:0] pc);
        return pc + XLEN'(INSTR_BYTES);
    endfunction

endpackage

// File: rtl/btb_pred_fifo.sv
// In-order queue of fetch-time predictions. Clear wins over push and pop in the
// same cycle; push on full and pop on empty are ignored.
module btb_pred_fifo
    import btb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic        pop,
    input  logic        clear,
    input  pred_entry_t wdata,
    output pred_entry_t rdata,
    output logic        full,
    output logic        empty,
    output logic [AW:0] count
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    pred_entry_t   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/btb_resolve.sv
// EX-stage branch resolution: compares the oldest recorded prediction with the
// resolved outcome, drives the BTB update port, redirects and keeps statistics.
module btb_resolve
    import btb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fetchValid,
    input  logic [31:0]      fetchPC,
    input  logic             predValid,
    input  logic             predTaken,
    input  logic [31:0]      predTarget,
    output logic             fetchReady,
    input  logic             exValid,
    input  logic [31:0]      exPC,
    input  logic             exIsBranch,
    input  logic             exTaken,
    input  logic [31:0]      exTarget,
    input  logic             flush,
    output logic             update,
    output logic [31:0]      updatePC,
    output logic [31:0]      updateTarget,
    output logic             mispredicted,
    output logic             redirect,
    output logic [31:0]      redirectPC,
    output logic             orderError,
    output logic [CNT_W-1:0] branchCount,
    output logic [CNT_W-1:0] mispredCount
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    pred_entry_t head;
    pred_entry_t wentry;
    logic        q_full;
    logic        q_empty;
    logic [AW:0] q_count;
    logic [AW:0] count_nxt;
    logic        push_fire;
    logic        pop_fire;
    logic        mispred_now;
    logic        clear_q;
    logic        err_now;
    logic [31:0] pred_next;
    logic [31:0] act_next;

    // Handshake: a push transfers when fetchValid && fetchReady at a rising edge;
    // fetchReady is a registered view of free space, so a pop never frees a slot
    // for a push in the same cycle. exValid has no back-pressure.
    assign pop_fire    = exValid && !q_empty;
    assign pred_next   = head.taken ? head.target : seq_pc(head.pc);
    assign act_next    = (exIsBranch && exTaken) ? exTarget : seq_pc(exPC);
    assign mispred_now = pop_fire && (act_next != pred_next);
    assign clear_q     = flush || mispred_now;
    assign push_fire   = fetchValid && fetchReady && !q_full && !clear_q;
    assign wentry      = '{pc: fetchPC, taken: predValid && predTaken, target: predTarget};
    assign err_now     = (fetchValid && !fetchReady)
                       || (exValid && q_empty)
                       || (pop_fire && (exPC != head.pc));

    btb_pred_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_fire),
        .pop   (pop_fire),
        .clear (clear_q),
        .wdata (wentry),
        .rdata (head),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    always_comb begin
        count_nxt = q_count + {{AW{1'b0}}, push_fire} - {{AW{1'b0}}, pop_fire};
        if (clear_q) count_nxt = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetchReady   <= 1'b0;
            update       <= 1'b0;
            updatePC     <= '0;
            updateTarget <= '0;
            mispredicted <= 1'b0;
            redirect     <= 1'b0;
            redirectPC   <= '0;
            orderError   <= 1'b0;
            branchCount  <= '0;
            mispredCount <= '0;
        end else begin
            fetchReady   <= (count_nxt < FULL_CNT);
            update       <= pop_fire && exIsBranch;
            mispredicted <= mispred_now;
            redirect     <= mispred_now;
            if (pop_fire && exIsBranch) begin
                updatePC     <= exPC;
                updateTarget <= exTaken ? exTarget : head.target;
            end
            if (mispred_now) redirectPC <= act_next;
            if (err_now) orderError <= 1'b1;
            if (pop_fire && exIsBranch && (branchCount != '1))
                branchCount <= branchCount + 1'b1;
            if (mispred_now && (mispredCount != '1))
                mispredCount <= mispredCount + 1'b1;
        end
    end

endmodule
